axi4lite_rr_arbiter: RTL and testbench

- Two-master round-robin arbiter that shares the slave-side AXI4-Lite channels between M0 and M1.
- It produces registered one-hot grants for the write path (AW/W/B) and the read path (AR/R), which the interconnect uses as mux selects. The interconnect forwards only the granted master's VALIDs.
- Write and read arbitration are independent.
- Each grant is held from the address request until the response handshake completes, so a slave never sees interleaved or mixed-master transactions.

---
 rtl/axi4lite_rr_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_axi4lite_rr_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi4lite_rr_arbiter
// Purpose  : Two-master round-robin arbiter for a shared AXI4-Lite slave.
//            Produces registered one-hot grants for the write path (AW/W/B)
//            and the read path (AR/R). Each grant is held from the address
//            request until the response handshake completes.
// Ports    : ACLK, ARESETn (async, active-low)
//            M0/M1_AWVALID, M0/M1_ARVALID  - master requests
//            S_* VALID/READY               - post-mux slave-side handshakes
//            WR_GNT, RD_GNT                - one-hot grants (bit0=M0, bit1=M1)
//            WR_BUSY, RD_BUSY              - channel FSM not idle
//            TO_ERR                        - one-cycle watchdog pulse
// Options  : `define AXI4LITE_ARB_TIMEOUT_EN builds per-channel watchdogs
//            that force release after TIMEOUT_CYCLES busy cycles.
// Revision : 1.0 - initial release
// ============================================================================
module axi4lite_rr_arbiter #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TO_W           = 9
) (
  input  logic       ACLK,
  input  logic       ARESETn,
  input  logic       M0_AWVALID,
  input  logic       M1_AWVALID,
  input  logic       M0_ARVALID,
  input  logic       M1_ARVALID,
  input  logic       S_AWVALID,
  input  logic       S_AWREADY,
  input  logic       S_WVALID,
  input  logic       S_WREADY,
  input  logic       S_BVALID,
  input  logic       S_BREADY,
  input  logic       S_ARVALID,
  input  logic       S_ARREADY,
  input  logic       S_RVALID,
  input  logic       S_RREADY,
  output logic [1:0] WR_GNT,
  output logic [1:0] RD_GNT,
  output logic       WR_BUSY,
  output logic       RD_BUSY,
  output logic       TO_ERR
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_REQ = 2'd1, W_RESP = 2'd2} wr_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_t;

  // One-hot winner; on contention the master that did not win last time wins.
  // last = 1 means M1 won last.
  function automatic logic [1:0] f_pick(input logic req0, input logic req1,
                                        input logic last);
    logic [1:0] res;
    res = 2'b00;
    if (req0 && req1) res = last ? 2'b01 : 2'b10;
    else if (req0)    res = 2'b01;
    else if (req1)    res = 2'b10;
    return res;
  endfunction

  wr_state_t  r_wr_state;
  rd_state_t  r_rd_state;
  logic [1:0] r_wr_gnt;
  logic [1:0] r_rd_gnt;
  logic       r_wr_last;
  logic       r_rd_last;
  logic       r_aw_done;
  logic       r_w_done;

  logic [1:0] w_wr_pick;
  logic [1:0] w_rd_pick;
  logic       w_aw_hs;
  logic       w_w_hs;
  logic       w_b_hs;
  logic       w_ar_hs;
  logic       w_r_hs;
  logic       w_wr_to;
  logic       w_rd_to;

  assign w_wr_pick = f_pick(M0_AWVALID, M1_AWVALID, r_wr_last);
  assign w_rd_pick = f_pick(M0_ARVALID, M1_ARVALID, r_rd_last);
  assign w_aw_hs   = S_AWVALID & S_AWREADY;
  assign w_w_hs    = S_WVALID  & S_WREADY;
  assign w_b_hs    = S_BVALID  & S_BREADY;
  assign w_ar_hs   = S_ARVALID & S_ARREADY;
  assign w_r_hs    = S_RVALID  & S_RREADY;

`ifdef AXI4LITE_ARB_TIMEOUT_EN
  localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_wr_cnt;
  logic [TO_W-1:0] r_rd_cnt;
  logic            r_to_err;

  assign w_wr_to = (r_wr_state != W_IDLE) && (r_wr_cnt == c_TO_LAST);
  assign w_rd_to = (r_rd_state != R_IDLE) && (r_rd_cnt == c_TO_LAST);

  // Counters sit at zero while idle, so every new grant starts from zero.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_to_err <= 1'b0;
    end else begin
      r_wr_cnt <= (r_wr_state == W_IDLE || w_wr_to) ? '0 : r_wr_cnt + 1'b1;
      r_rd_cnt <= (r_rd_state == R_IDLE || w_rd_to) ? '0 : r_rd_cnt + 1'b1;
      // Simultaneous expiry on both channels merges into one pulse.
      r_to_err <= w_wr_to | w_rd_to;
    end
  end

  assign TO_ERR = r_to_err;
`else
  assign w_wr_to = 1'b0;
  assign w_rd_to = 1'b0;
  assign TO_ERR  = 1'b0;

  // Watchdog parameters only matter when the watchdog is built.
  if (TIMEOUT_CYCLES > 0 && TO_W > 0) begin : g_param_ok
  end
`endif

  // Write channel FSM.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wr_state <= W_IDLE;
      r_wr_gnt   <= 2'b00;
      r_wr_last  <= 1'b1;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else if (w_wr_to) begin
      r_wr_state <= W_IDLE;
      r_wr_gnt   <= 2'b00;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (|w_wr_pick) begin
            r_wr_gnt   <= w_wr_pick;
            r_wr_last  <= w_wr_pick[1];
            r_wr_state <= W_REQ;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
          end
        end
        W_REQ: begin
          // AW and W may complete in either order or together.
          if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
            r_wr_state <= W_RESP;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
          end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
          end
        end
        W_RESP: begin
          if (w_b_hs) begin
            r_wr_state <= W_IDLE;
            r_wr_gnt   <= 2'b00;
          end
        end
        default: begin
          r_wr_state <= W_IDLE;
          r_wr_gnt   <= 2'b00;
        end
      endcase
    end
  end

  // Read channel FSM.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rd_state <= R_IDLE;
      r_rd_gnt   <= 2'b00;
      r_rd_last  <= 1'b1;
    end else if (w_rd_to) begin
      r_rd_state <= R_IDLE;
      r_rd_gnt   <= 2'b00;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (|w_rd_pick) begin
            r_rd_gnt   <= w_rd_pick;
            r_rd_last  <= w_rd_pick[1];
            r_rd_state <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (w_ar_hs) r_rd_state <= R_DATA;
        end
        R_DATA: begin
          if (w_r_hs) begin
            r_rd_state <= R_IDLE;
            r_rd_gnt   <= 2'b00;
          end
        end
        default: begin
          r_rd_state <= R_IDLE;
          r_rd_gnt   <= 2'b00;
        end
      endcase
    end
  end

  assign WR_GNT  = r_wr_gnt;
  assign RD_GNT  = r_rd_gnt;
  assign WR_BUSY = (r_wr_state != W_IDLE);
  assign RD_BUSY = (r_rd_state != R_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4lite_rr_arbiter
// Purpose  : Directed self-checking bench for axi4lite_rr_arbiter. Expected
//            grants are queued when requests are driven and popped when the
//            grant is sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4lite_rr_arbiter;

  logic       ACLK;
  logic       ARESETn;
  logic       M0_AWVALID, M1_AWVALID, M0_ARVALID, M1_ARVALID;
  logic       S_AWVALID, S_AWREADY, S_WVALID, S_WREADY, S_BVALID, S_BREADY;
  logic       S_ARVALID, S_ARREADY, S_RVALID, S_RREADY;
  logic [1:0] WR_GNT, RD_GNT;
  logic       WR_BUSY, RD_BUSY, TO_ERR;

  int n_chk  = 0;
  int n_fail = 0;

  logic [1:0] q_wr[$];
  logic [1:0] q_rd[$];

  axi4lite_rr_arbiter #(
    .TIMEOUT_CYCLES(16),
    .TO_W          (5)
  ) u_dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .M0_AWVALID(M0_AWVALID),
    .M1_AWVALID(M1_AWVALID),
    .M0_ARVALID(M0_ARVALID),
    .M1_ARVALID(M1_ARVALID),
    .S_AWVALID (S_AWVALID),
    .S_AWREADY (S_AWREADY),
    .S_WVALID  (S_WVALID),
    .S_WREADY  (S_WREADY),
    .S_BVALID  (S_BVALID),
    .S_BREADY  (S_BREADY),
    .S_ARVALID (S_ARVALID),
    .S_ARREADY (S_ARREADY),
    .S_RVALID  (S_RVALID),
    .S_RREADY  (S_RREADY),
    .WR_GNT    (WR_GNT),
    .RD_GNT    (RD_GNT),
    .WR_BUSY   (WR_BUSY),
    .RD_BUSY   (RD_BUSY),
    .TO_ERR    (TO_ERR)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // One clock: the DUT updates on posedge, the bench samples and drives on negedge.
  task automatic tick();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag);
    logic [1:0] e;
    if (q_wr.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s observed=%b expected=<empty scoreboard>", tag, WR_GNT);
    end else begin
      e = q_wr.pop_front();
      chk(tag, WR_GNT, e);
    end
  endtask

  task automatic chk_rd(input string tag);
    logic [1:0] e;
    if (q_rd.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s observed=%b expected=<empty scoreboard>", tag, RD_GNT);
    end else begin
      e = q_rd.pop_front();
      chk(tag, RD_GNT, e);
    end
  endtask

  task automatic clear_inputs();
    M0_AWVALID = 0; M1_AWVALID = 0; M0_ARVALID = 0; M1_ARVALID = 0;
    S_AWVALID = 0; S_AWREADY = 0; S_WVALID = 0; S_WREADY = 0;
    S_BVALID = 0; S_BREADY = 0; S_ARVALID = 0; S_ARREADY = 0;
    S_RVALID = 0; S_RREADY = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    ARESETn = 0;
    tick();
    ARESETn = 1;
    tick();
  endtask

  task automatic hs_aw_w();
    S_AWVALID = 1; S_AWREADY = 1; S_WVALID = 1; S_WREADY = 1;
    tick();
    S_AWVALID = 0; S_AWREADY = 0; S_WVALID = 0; S_WREADY = 0;
  endtask

  task automatic hs_b();
    S_BVALID = 1; S_BREADY = 1;
    tick();
    S_BVALID = 0; S_BREADY = 0;
  endtask

  task automatic hs_ar();
    S_ARVALID = 1; S_ARREADY = 1;
    tick();
    S_ARVALID = 0; S_ARREADY = 0;
  endtask

  task automatic hs_r();
    S_RVALID = 1; S_RREADY = 1;
    tick();
    S_RVALID = 0; S_RREADY = 0;
  endtask

  initial begin
    clear_inputs();
    ARESETn = 0;
    tick();
    tick();
    chk("rst_wr_gnt", WR_GNT, 2'b00);
    chk("rst_rd_gnt", RD_GNT, 2'b00);
    chk("rst_wr_busy", {1'b0, WR_BUSY}, 2'b00);
    chk("rst_rd_busy", {1'b0, RD_BUSY}, 2'b00);
    chk("rst_to_err", {1'b0, TO_ERR}, 2'b00);
    ARESETn = 1;
    tick();

    // Handshakes while idle change nothing.
    S_AWVALID = 1; S_AWREADY = 1; S_WVALID = 1; S_WREADY = 1;
    S_BVALID = 1; S_BREADY = 1; S_ARVALID = 1; S_ARREADY = 1;
    S_RVALID = 1; S_RREADY = 1;
    tick();
    clear_inputs();
    chk("idle_hs_wr_busy", {1'b0, WR_BUSY}, 2'b00);
    chk("idle_hs_rd_busy", {1'b0, RD_BUSY}, 2'b00);

    // Single M0 write, one-cycle grant latency, AW+W together.
    M0_AWVALID = 1;
    q_wr.push_back(2'b01);
    tick();
    chk_wr("t1_grant");
    chk("t1_busy", {1'b0, WR_BUSY}, 2'b01);
    M0_AWVALID = 0;
    hs_aw_w();
    chk("t1_resp_hold", WR_GNT, 2'b01);
    hs_b();
    chk("t1_release", WR_GNT, 2'b00);
    chk("t1_idle_busy", {1'b0, WR_BUSY}, 2'b00);

    // Contended back-to-back writes alternate with exactly one idle cycle.
    do_reset();
    M0_AWVALID = 1; M1_AWVALID = 1;
    for (int i = 0; i < 4; i++) begin
      q_wr.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      chk_wr("t2_rr_grant");
      hs_aw_w();
      hs_b();
      if (i == 3) begin
        M0_AWVALID = 0; M1_AWVALID = 0;
      end
      chk("t2_gap", WR_GNT, 2'b00);
    end
    tick();
    chk("t2_stays_idle", WR_GNT, 2'b00);

    // W three cycles before AW; B during W_REQ is ignored.
    do_reset();
    M1_AWVALID = 1;
    q_wr.push_back(2'b10);
    tick();
    chk_wr("t3_grant");
    M1_AWVALID = 0;
    S_WVALID = 1; S_WREADY = 1;
    tick();
    S_WVALID = 0; S_WREADY = 0;
    chk("t3_after_w", WR_GNT, 2'b10);
    hs_b();
    chk("t3_b_in_req_ignored", WR_GNT, 2'b10);
    tick();
    S_AWVALID = 1; S_AWREADY = 1;
    tick();
    S_AWVALID = 0; S_AWREADY = 0;
    chk("t3_after_aw", WR_GNT, 2'b10);
    hs_b();
    chk("t3_release", WR_GNT, 2'b00);

    // Independent read and write grants on the same edge.
    do_reset();
    M0_ARVALID = 1; M1_AWVALID = 1;
    q_rd.push_back(2'b01);
    q_wr.push_back(2'b10);
    tick();
    chk_rd("t4_rd_grant");
    chk_wr("t4_wr_grant");
    M0_ARVALID = 0; M1_AWVALID = 0;
    hs_ar();
    hs_aw_w();
    hs_r();
    chk("t4_rd_release", RD_GNT, 2'b00);
    chk("t4_wr_hold", WR_GNT, 2'b10);
    chk("t4_rd_busy", {1'b0, RD_BUSY}, 2'b00);
    hs_b();
    chk("t4_wr_release", WR_GNT, 2'b00);

    // Asynchronous reset in R_DATA, then contended read goes to M0.
    M1_ARVALID = 1;
    q_rd.push_back(2'b10);
    tick();
    chk_rd("t5_grant");
    M1_ARVALID = 0;
    hs_ar();
    chk("t5_in_data", RD_GNT, 2'b10);
    #2 ARESETn = 0;
    #1;
    chk("t5_async_gnt", RD_GNT, 2'b00);
    chk("t5_async_busy", {1'b0, RD_BUSY}, 2'b00);
    #1 ARESETn = 1;
    @(negedge ACLK);
    M0_ARVALID = 1; M1_ARVALID = 1;
    q_rd.push_back(2'b01);
    tick();
    chk_rd("t5_post_rst_grant");
    M0_ARVALID = 0; M1_ARVALID = 0;
    hs_ar();
    hs_r();
    chk("t5_release", RD_GNT, 2'b00);

`ifdef AXI4LITE_ARB_TIMEOUT_EN
    // Watchdog: grant M1 and withhold B.
    do_reset();
    M1_AWVALID = 1;
    q_wr.push_back(2'b10);
    tick();
    chk_wr("t6_grant");
    M1_AWVALID = 0;
    hs_aw_w();
    for (int k = 2; k <= 16; k++) begin
      chk("t6_busy_hold", {1'b0, WR_BUSY}, 2'b01);
      chk("t6_no_pulse_yet", {1'b0, TO_ERR}, 2'b00);
      tick();
    end
    chk("t6_released", WR_GNT, 2'b00);
    chk("t6_to_pulse", {1'b0, TO_ERR}, 2'b01);
    M0_AWVALID = 1; M1_AWVALID = 1;
    q_wr.push_back(2'b01);
    tick();
    chk("t6_pulse_single", {1'b0, TO_ERR}, 2'b00);
    chk_wr("t6_next_grant");
    M0_AWVALID = 0; M1_AWVALID = 0;
    hs_aw_w();
    hs_b();
`else
    // No watchdog: a grant is held indefinitely.
    do_reset();
    M1_AWVALID = 1;
    q_wr.push_back(2'b10);
    tick();
    chk_wr("t6_grant");
    M1_AWVALID = 0;
    hs_aw_w();
    for (int k = 0; k < 300; k++) tick();
    chk("t6_long_hold", WR_GNT, 2'b10);
    chk("t6_no_to_err", {1'b0, TO_ERR}, 2'b00);
    hs_b();
    chk("t6_release", WR_GNT, 2'b00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
